uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART byte receiver (27 MHz clock, 115200 baud).
- Turns the receiver's byte stream into validated command frames: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
- Presents each accepted frame to the controller core as a one-cycle strobe with held fields.
- Rejects malformed or stalled frames and reports why.

Parameters:
- MAX_LEN, 8, maximum payload bytes per frame (1..15).
- SYNC_BYTE, 8'hAA, frame start marker.
- TIMEOUT_CYCLES, 27000, maximum clock cycles between bytes inside a frame (1 ms); must be < 65536.

Ports:
- clock  input  1  system clock, 27 MHz.
- rst  input  1  asynchronous active-low reset.
- byte_avail  input  1  receiver avail level; a rising edge marks a new byte.
- byte_data  input  8  receiver data; stable while byte_avail is high.
- cmd_valid  output  1  one-cycle pulse, frame accepted.
- cmd  output  8  command byte of the last accepted frame.
- cmd_len  output  4  payload length of the last accepted frame.
- payload  output  8*MAX_LEN  payload; byte i at [8i+7:8i]; bytes at index >= cmd_len are zero.
- err  output  1  one-cycle pulse, frame rejected.
- err_code  output  2  1 = LEN > MAX_LEN, 2 = checksum mismatch, 3 = inter-byte timeout; held until the next err.

Behaviour:
- Reset (rst low, asynchronous): every output is 0, state = HUNT, avail_q = 0, counters cleared, payload buffer cleared.
- Byte strobe:
  - strobe = byte_avail & ~avail_q; avail_q is byte_avail registered every cycle.
  - byte_data is sampled at the edge where strobe = 1.
- Spurious strobes are harmless: the receiver raises avail with data 0x00 after reset and after a framing error, and these are discarded in HUNT because they are not SYNC_BYTE.
- States and transitions (all transitions on a strobe unless noted):
  - HUNT: byte == SYNC_BYTE -> GET_CMD; any other byte stays in HUNT silently.
  - GET_CMD: store cmd, chk_acc = byte -> GET_LEN.
  - GET_LEN:
    - byte[7:0] > MAX_LEN -> err, code 1, -> HUNT.
    - Otherwise store len, chk_acc ^= byte, clear the payload buffer, idx = 0.
    - len == 0 -> GET_CHK; else -> GET_PAY.
  - GET_PAY: buf[idx] = byte, chk_acc ^= byte, idx++; when idx reaches len-1 -> GET_CHK.
  - GET_CHK:
    - byte == chk_acc -> copy buf/cmd/len to the output registers, pulse cmd_valid, -> HUNT.
    - Otherwise err, code 2, -> HUNT; outputs are unchanged.
- Latency: cmd_valid / err go high in the cycle after the edge that sampled the CHK byte (registered) and last exactly 1 cycle.
- Output fields update in the same cycle cmd_valid rises and hold until the next accepted frame; rejected frames never alter them.
- Timeout:
  - A 16-bit gap counter is cleared on every strobe and held at 0 in HUNT; it increments each cycle in the other states.
  - Reaching TIMEOUT_CYCLES -> err, code 3, -> HUNT.
  - A strobe in the same cycle as the timeout wins: the byte is processed and the counter is cleared.
- SYNC_BYTE arriving inside a frame is treated as ordinary data; there is no resync mid-frame.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes; SYNC is excluded.
- Reset mid-frame: frame discarded, outputs return to 0 immediately.

Optional Feature:
- UART_CMD_STATS_EN defined:
  - Adds outputs frame_cnt[7:0] and err_cnt[7:0], both reset to 0 and saturating at 255.
  - frame_cnt increments on each cmd_valid; err_cnt increments on each err.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Bytes AA 01 02 10 20 33 -> one cmd_valid pulse, cmd = 01, cmd_len = 2, payload[15:0] = 2010, upper payload bytes = 0, err never asserted.
- Reset release followed by the receiver's idle 0x00 strobe, then AA 05 00 05 -> the 0x00 is ignored; cmd_valid with cmd = 05, cmd_len = 0, payload = 0.
- AA 01 02 10 20 34 -> err pulse with err_code = 2; cmd / cmd_len / payload keep their previous values; a following valid frame is accepted.
- AA 01 09 -> err, code 1, immediately after the LEN byte; a next AA 02 01 7F 7C is accepted with cmd = 02 and payload byte 0 = 7F.
- AA 01 02 10, then silence for 27000 cycles -> err, code 3 at exactly the timeout; the state returns to HUNT. Repeat with the next strobe landing on the timeout cycle -> no err.
- rst asserted between payload bytes -> all outputs 0 asynchronously; after release a full valid frame parses correctly. With UART_CMD_STATS_EN, 300 good frames -> frame_cnt = 255.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - SYNC/CMD/LEN/PAYLOAD/CHK frame parser on the UART receiver byte stream
// Optional frame/error counters are enabled by defining UART_CMD_STATS_EN.
module uart_cmd_parser #(
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 27000
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 byte_avail,
    input  logic [7:0]           byte_data,
    output logic                 cmd_valid,
    output logic [7:0]           cmd,
    output logic [3:0]           cmd_len,
    output logic [8*MAX_LEN-1:0] payload,
    output logic                 err,
    output logic [1:0]           err_code
`ifdef UART_CMD_STATS_EN
    ,
    output logic [7:0]           frame_cnt,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic [2:0] {HUNT, GET_CMD, GET_LEN, GET_PAY, GET_CHK} state_t;

    localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);
    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 avail_q;
    logic [7:0]           cmd_buf_q, cmd_buf_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           idx_q, idx_d;
    logic [7:0]           chk_q, chk_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic [15:0]          gap_q, gap_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [7:0]           cmd_out_q, cmd_out_d;
    logic [3:0]           cmd_len_q, cmd_len_d;
    logic [8*MAX_LEN-1:0] payload_q, payload_d;
    logic                 strobe;
`ifdef UART_CMD_STATS_EN
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        strobe      = byte_avail & ~avail_q;
        state_d     = state_q;
        cmd_buf_d   = cmd_buf_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        buf_d       = buf_q;
        gap_d       = gap_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        cmd_out_d   = cmd_out_q;
        cmd_len_d   = cmd_len_q;
        payload_d   = payload_q;

        if (state_q == HUNT) begin
            gap_d = '0;
            if (strobe && byte_data == SYNC_BYTE)
                state_d = GET_CMD;
        end else if (strobe) begin
            // A byte landing on the timeout cycle is still processed.
            gap_d = '0;
            case (state_q)
                GET_CMD: begin
                    cmd_buf_d = byte_data;
                    chk_d     = byte_data;
                    state_d   = GET_LEN;
                end
                GET_LEN: begin
                    if (byte_data > LEN_MAX) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = HUNT;
                    end else begin
                        len_d   = byte_data[3:0];
                        chk_d   = chk_q ^ byte_data;
                        buf_d   = '0;
                        idx_d   = '0;
                        state_d = (byte_data == 8'd0) ? GET_CHK : GET_PAY;
                    end
                end
                GET_PAY: begin
                    for (int i = 0; i < MAX_LEN; i++)
                        if (idx_q == 4'(i))
                            buf_d[8*i +: 8] = byte_data;
                    chk_d = chk_q ^ byte_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == len_q - 4'd1)
                        state_d = GET_CHK;
                end
                GET_CHK: begin
                    if (byte_data == chk_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_out_d   = cmd_buf_q;
                        cmd_len_d   = len_q;
                        payload_d   = buf_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (gap_q == GAP_LAST) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
            state_d    = HUNT;
            gap_d      = '0;
        end else begin
            gap_d = gap_q + 16'd1;
        end
    end

`ifdef UART_CMD_STATS_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (cmd_valid_d && frame_cnt_q != 8'hFF)
            frame_cnt_d = frame_cnt_q + 8'd1;
        if (err_d && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            avail_q     <= 1'b0;
            cmd_buf_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            buf_q       <= '0;
            gap_q       <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            cmd_out_q   <= '0;
            cmd_len_q   <= '0;
            payload_q   <= '0;
`ifdef UART_CMD_STATS_EN
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            avail_q     <= byte_avail;
            cmd_buf_q   <= cmd_buf_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            buf_q       <= buf_d;
            gap_q       <= gap_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_out_q   <= cmd_out_d;
            cmd_len_q   <= cmd_len_d;
            payload_q   <= payload_d;
`ifdef UART_CMD_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_out_q;
    assign cmd_len   = cmd_len_q;
    assign payload   = payload_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
`ifdef UART_CMD_STATS_EN
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SYNC    = 8'hAA;
    localparam int         TMO     = 27000;

    logic                 clock = 1'b0;
    logic                 rst = 1'b0;
    logic                 byte_avail = 1'b0;
    logic [7:0]           byte_data = 8'h00;
    logic                 cmd_valid;
    logic [7:0]           cmd;
    logic [3:0]           cmd_len;
    logic [8*MAX_LEN-1:0] payload;
    logic                 err;
    logic [1:0]           err_code;
`ifdef UART_CMD_STATS_EN
    logic [7:0]           frame_cnt;
    logic [7:0]           err_cnt;
`endif

    uart_cmd_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .rst(rst), .byte_avail(byte_avail), .byte_data(byte_data),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len), .payload(payload),
        .err(err), .err_code(err_code)
`ifdef UART_CMD_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pay;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  m_cmd = 0;
    logic [3:0]  m_len = 0;
    logic [63:0] m_pay = 0;
    logic [1:0]  m_code = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic is_err);
        exp_t e;
        e.is_err = is_err;
        e.code   = m_code;
        e.cmd    = m_cmd;
        e.len    = m_len;
        e.pay    = m_pay;
        sb.push_back(e);
    endtask

    // Returns at the negedge right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_avail = 1'b1;
        byte_data  = b;
        @(negedge clock);
        byte_avail = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input int n, input logic [63:0] p, input bit bad);
        logic [7:0] chk;
        logic [7:0] b;
        chk = c ^ 8'(n);
        send_byte(SYNC);
        send_byte(c);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            b = p[8*i +: 8];
            chk ^= b;
            send_byte(b);
        end
        if (bad) begin
            m_code = 2'd2;
        end else begin
            m_cmd = c;
            m_len = 4'(n);
            m_pay = '0;
            for (int i = 0; i < n; i++) m_pay[8*i +: 8] = p[8*i +: 8];
        end
        push_exp(bad);
        send_byte(bad ? ~chk : chk);
        check("pulse_latency", {62'd0, cmd_valid, err}, bad ? 64'd1 : 64'd2);
        @(negedge clock);
        check("pulse_width", {62'd0, cmd_valid, err}, 64'd0);
    endtask

    always @(negedge clock) begin
        if (rst && (cmd_valid || err)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_event: observed valid=%0b err=%0b expected none", cmd_valid, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_kind", {62'd0, cmd_valid, err}, e.is_err ? 64'd1 : 64'd2);
                check("sb_err_code", 64'(err_code), 64'(e.code));
                check("sb_cmd", 64'(cmd), 64'(e.cmd));
                check("sb_len", 64'(cmd_len), 64'(e.len));
                check("sb_payload", payload, e.pay);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_outputs", {cmd_valid, err, err_code, cmd, cmd_len, payload[43:0]}, 64'd0);
        check("rst_payload", payload, 64'd0);
        rst = 1'b1;

        // Receiver idle 0x00 strobe after reset is discarded.
        send_byte(8'h00);
        send_frame(8'h05, 0, 64'd0, 1'b0);

        send_frame(8'h01, 2, 64'h2010, 1'b0);
        check("upper_payload_zero", payload[63:16], 64'd0);

        send_frame(8'h01, 2, 64'h2010, 1'b1);
        send_frame(8'h03, 1, 64'h44, 1'b0);

        // LEN above MAX_LEN: error right after LEN byte.
        m_code = 2'd1;
        push_exp(1'b1);
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h09);
        check("len_err_now", 64'(err), 64'd1);
        @(negedge clock);
        send_frame(8'h02, 1, 64'h7F, 1'b0);

        send_frame(8'h08, MAX_LEN, 64'h8877665544332211, 1'b0);
        send_frame(8'h06, 1, 64'hAA, 1'b0);
        check("err_code_held", 64'(err_code), 64'd1);

        // Timeout fires exactly TMO cycles after the last strobe.
        m_code = 2'd3;
        push_exp(1'b1);
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10);
        repeat (TMO - 1) @(negedge clock);
        check("tmo_not_early", 64'(err), 64'd0);
        @(negedge clock);
        check("tmo_fire", {62'd0, err, cmd_valid}, 64'd2);
        @(negedge clock);

        // Strobe landing on the timeout cycle wins.
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10);
        repeat (TMO - 2) @(negedge clock);
        send_byte(8'h20);
        check("tmo_race_no_err", 64'(err), 64'd0);
        m_cmd = 8'h01;
        m_len = 4'd2;
        m_pay = 64'h2010;
        push_exp(1'b0);
        send_byte(8'h33);
        check("tmo_race_valid", 64'(cmd_valid), 64'd1);
        @(negedge clock);

        // Asynchronous reset mid-frame.
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h11);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outputs", {cmd_valid, err, err_code, cmd, cmd_len, payload[43:0]}, 64'd0);
        check("async_rst_payload", payload, 64'd0);
        m_cmd = 0; m_len = 0; m_pay = 0; m_code = 0;
        @(negedge clock);
        rst = 1'b1;
        send_frame(8'h04, 1, 64'h55, 1'b0);

`ifdef UART_CMD_STATS_EN
        check("err_cnt_after_rst", 64'(err_cnt), 64'd0);
        for (int k = 0; k < 300; k++) send_frame(8'h07, 0, 64'd0, 1'b0);
        check("frame_cnt_sat", 64'(frame_cnt), 64'd255);
        check("err_cnt_zero", 64'(err_cnt), 64'd0);
`endif

        repeat (4) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
